// File: rtl/or_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | or_pkg : shared state encoding and default sizes for the OR accumulator    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package or_pkg;

   localparam int C_WIDTH_DEFAULT  = 16;
   localparam int C_WINDOW_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage : or_pkg
`default_nettype wire

// File: rtl/or_word.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | or_word : combinational WIDTH-bit bitwise OR, one two-input Or per bit     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module or_word #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign y[i] = a[i] | b[i];
   end

endmodule : or_word
`default_nettype wire

// File: rtl/or_window_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | or_window_acc : folds up to WINDOW words into a sticky OR, holds until     |
// | taken; valid/ready on both sides, flush closes a partial window early.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module or_window_acc
   import or_pkg::*;
#(
   parameter int WIDTH  = C_WIDTH_DEFAULT,
   parameter int WINDOW = C_WINDOW_DEFAULT,
   parameter int CNT_W  = $clog2(WINDOW + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [WIDTH-1:0] out,
   output logic             out_any,
   output logic [CNT_W-1:0] out_count,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [CNT_W-1:0] c_window = CNT_W'(WINDOW);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] w_acc_next;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_next;
   logic [CNT_W-1:0] w_count_inc;
   logic [WIDTH-1:0] w_or;
   logic             w_accept;

   or_word #(
      .WIDTH (WIDTH)
   ) u_or_word (
      .a (r_acc),
      .b (in_data),
      .y (w_or)
   );

   // in_ready is a pure function of state so no combinational path crosses the block
   assign in_ready    = (r_state != HOLD);
   assign w_accept    = in_valid & in_ready;
   assign w_count_inc = r_count + CNT_W'(1);

   assign out       = r_acc;
   assign out_any   = |r_acc;
   assign out_count = r_count;
   assign out_valid = (r_state == HOLD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         r_acc   <= w_acc_next;
         r_count <= w_count_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_acc_next   = r_acc;
      w_count_next = r_count;
      case (r_state)
         IDLE: begin
            // a lone flush here is dropped: empty results are never emitted
            if (w_accept) begin
               w_acc_next   = in_data;
               w_count_next = CNT_W'(1);
               w_state_next = ((WINDOW == 1) || flush) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (w_accept) begin
               w_acc_next   = w_or;
               w_count_next = w_count_inc;
               if ((w_count_inc == c_window) || flush) begin
                  w_state_next = HOLD;
               end
            end else if (flush) begin
               w_state_next = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               w_state_next = IDLE;
               w_acc_next   = '0;
               w_count_next = '0;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_acc_next   = '0;
            w_count_next = '0;
         end
      endcase
   end

endmodule : or_window_acc
`default_nettype wire

// File: doc/or_window_acc.md
# or_window_acc

Parametrised successor to the two-input Or gate: a clocked W-bit OR accumulator that folds a stream of words into one result over a window of up to WINDOW words, then holds the result until taken. It sits between word-producing logic (ALU/flag paths) and consumers that need a sticky "any bit ever set" summary: interrupt/flag collection, zero-detect across multi-word operands. Input and output use valid/ready handshakes. An early flush closes a partial window.

## Interface
- WIDTH, 16: data word width, ≥1.
- WINDOW, 4: maximum words per result, ≥1.
- CNT_W, $clog2(WINDOW+1): derived width of the word counter; do not override.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- in_data  in  WIDTH  word to OR into the accumulator.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a word this cycle.
- flush  in  1  close the current window early.
- out  out  WIDTH  accumulated OR result (registered).
- out_any  out  1  reduction OR of out.
- out_count  out  CNT_W  number of words folded into out.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.

## Operation
- Accept = in_valid & in_ready at a rising edge.
- States:
  - IDLE: acc=0, count=0, in_ready=1, out_valid=0.
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- IDLE, accept: acc←in_data, count←1. Next state is HOLD if WINDOW==1 or flush=1, else ACCUM.
- IDLE, flush without accept: ignored. An empty result is never produced.
- ACCUM, accept: acc←acc|in_data, count←count+1. Goes to HOLD when new count==WINDOW.
- ACCUM, flush=1: goes to HOLD. If an accept happens in the same cycle, that word is folded in first.
- ACCUM, neither accept nor flush: holds state; idle cycles are legal.
- HOLD: out, out_count, out_any stable. in_data, in_valid and flush are ignored.
- HOLD, out_ready=1: goes to IDLE with acc=0, count=0.
- out is driven from acc in every state. out_count is count. out_any=|acc, combinational from the register.
- Arithmetic:
  - acc is exactly WIDTH bits.
  - count never exceeds WINDOW and never wraps.
  - No X-propagation filtering: an X on an accepted in_data bit may appear on out.

## Timing
- Reset (async assert, released synchronously in the bench):
  - state=IDLE.
  - out=0, out_any=0, out_count=0, out_valid=0, in_ready=1.
- Latency: out_valid rises on the clock edge that accepts the closing word (or the flush edge). The result is visible one cycle after the last input is presented.
- Throughput:
  - One word per clock while in ACCUM.
  - At least one HOLD cycle per result, so there is a one-cycle bubble minimum between windows.
  - No bypass from HOLD to accepting input.
- in_ready depends only on state, never combinationally on out_ready or in_valid.
- Back-pressure: out_ready=0 holds HOLD indefinitely with all outputs stable.
- Reset mid-window or in HOLD: the partial or pending result is discarded and outputs return immediately (asynchronously) to reset values.

## Structure
- Shared package or_pkg:
  - state typedef (IDLE, ACCUM, HOLD), 2-bit encoding.
  - Default WIDTH and WINDOW constants.
- Sub-module or_word: a combinational WIDTH-bit bitwise OR of two words, built from the existing Or gate per bit. It is instantiated once for acc|in_data.
- The top level holds the state register, acc, count and handshake logic.

## Test plan
- Reset, then four accepts (0x0001, 0x0010, 0x0100, 0x1000) with out_ready=0, WINDOW=4 → HOLD with out=0x1111, out_count=4, out_any=1, in_ready=0. Outputs stay stable 5 cycles; out_ready=1 → IDLE, out=0.
- Two accepts (0x00F0, 0x000F), then flush alone → out=0x00FF, out_count=2. Flush in IDLE with no accept → no out_valid.
- Accept 0x8000 with flush in the same cycle from IDLE → HOLD next cycle, out=0x8000, out_count=1.
- Four accepts of 0x0000 → out=0, out_any=0, out_count=4, out_valid=1.
- Gapped input (in_valid toggling) plus in_valid held high during HOLD → held words are not consumed; the next window starts only after out_ready.
- Reset asserted mid-ACCUM with acc=0x0F0F → out=0, out_count=0, out_valid=0, in_ready=1 immediately. Rerun with WIDTH=8, WINDOW=1: every accept yields HOLD directly.
